// File: rtl/frame_mem_read_arb.sv
// rtl/frame_mem_read_arb.sv - NCH-channel round-robin/fixed-priority arbiter for the memory read port
// Define RDATA_REG_EN to register ch_rvalid/ch_rdata/ch_rerr (latency MEM_LAT+1).
module frame_mem_read_arb #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 8,
  parameter int NCH       = 3,
  parameter int MEM_DEPTH = 262144,
  parameter int MEM_LAT   = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH*ADDR_W-1:0] ch_addr,
  output logic [NCH-1:0]        ch_ack,
  output logic [NCH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]     ch_rdata,
  output logic                  ch_rerr,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_q
);
  localparam int PTR_W = $clog2(NCH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

  logic [PTR_W-1:0]  rr_ptr;
  logic [NCH-1:0]    hi_mask, req_hi, pick, gnt_oh;
  logic              gnt_vld, gnt_oor;
  logic [PTR_W-1:0]  gnt_idx;
  logic [ADDR_W-1:0] sel_addr, gnt_addr, mem_addr_q;

  // Tag pipeline: bit 0 is the newest entry, MEM_LAT-1 lines up with mem_q.
  logic [MEM_LAT-1:0]            pv, perr;
  logic [MEM_LAT-1:0][PTR_W-1:0] pch;
  logic                          tail_v, tail_err;
  logic [PTR_W-1:0]              tail_ch;
  logic [NCH-1:0]                rv_d;
  logic [DATA_W-1:0]             rd_d;
  logic                          re_d;

  assign tail_v   = pv[MEM_LAT-1];
  assign tail_err = perr[MEM_LAT-1];
  assign tail_ch  = pch[MEM_LAT-1];

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    hi_mask  = '0;
    rv_d     = '0;
    gnt_idx  = '0;
    sel_addr = '0;
    for (int i = 0; i < NCH; i++) begin
      idx          = PTR_W'(i);
      hi_mask[idx] = (idx >= rr_ptr);
      rv_d[idx]    = tail_v && (tail_ch == idx);
    end
    // Requesters at or above rr_ptr win first; otherwise wrap to the lowest requester.
    req_hi = ch_req & hi_mask;
    pick   = (PRIO_MODE == 0 && req_hi != '0) ? req_hi : ch_req;
    gnt_oh = pick & ~(pick - NCH'(1));
    for (int i = 0; i < NCH; i++) begin
      idx = PTR_W'(i);
      if (gnt_oh[idx]) begin
        gnt_idx  = idx;
        sel_addr = ADDR_W'(ch_addr >> (i * ADDR_W));
      end
    end
  end

  assign gnt_vld  = rst && (ch_req != '0);
  assign ch_ack   = gnt_vld ? gnt_oh : '0;
  assign gnt_oor  = {1'b0, sel_addr} >= DEPTH_C;
  assign gnt_addr = gnt_oor ? '0 : sel_addr;
  assign mem_addr = gnt_vld ? gnt_addr : mem_addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr     <= '0;
      mem_addr_q <= '0;
      pv         <= '0;
      perr       <= '0;
      pch        <= '0;
    end else begin
      pv   <= MEM_LAT'({pv, gnt_vld});
      perr <= MEM_LAT'({perr, gnt_vld && gnt_oor});
      pch  <= (MEM_LAT*PTR_W)'({pch, gnt_idx});
      if (gnt_vld) begin
        mem_addr_q <= gnt_addr;
        if (PRIO_MODE == 0)
          rr_ptr <= (gnt_idx == PTR_W'(NCH-1)) ? '0 : gnt_idx + PTR_W'(1);
      end
    end
  end

  // Out-of-range reads still hit address 0; their data is forced to zero here.
  assign rd_d = (tail_v && !tail_err) ? mem_q : '0;
  assign re_d = tail_v && tail_err;

`ifdef RDATA_REG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_rvalid <= '0;
      ch_rdata  <= '0;
      ch_rerr   <= 1'b0;
    end else begin
      ch_rvalid <= rv_d;
      ch_rdata  <= rd_d;
      ch_rerr   <= re_d;
    end
  end
`else
  assign ch_rvalid = rv_d;
  assign ch_rdata  = rd_d;
  assign ch_rerr   = re_d;
`endif

endmodule

// File: tb/tb_frame_mem_read_arb.sv
// tb/tb_frame_mem_read_arb.sv - table, directed and randomized checks of frame_mem_read_arb
// Two instances: round-robin with MEM_LAT=2, fixed priority with MEM_LAT=1.
module tb_frame_mem_read_arb;
  localparam int NCH = 3;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int DEPTH = 1024;
  localparam int LAT_R = 2;
  localparam int LAT_P = 1;
`ifdef RDATA_REG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req_r, req_p, ack_r, ack_p, rv_r, rv_p;
  logic [95:0] adr_r, adr_p;
  logic [7:0]  rd_r, rd_p, q_r, q1_r, q_p;
  logic        re_r, re_p;
  logic [31:0] ma_r, ma_p;

  frame_mem_read_arb #(.ADDR_W(AW), .DATA_W(DW), .NCH(NCH), .MEM_DEPTH(DEPTH),
                       .MEM_LAT(LAT_R), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .ch_req(req_r), .ch_addr(adr_r), .ch_ack(ack_r),
    .ch_rvalid(rv_r), .ch_rdata(rd_r), .ch_rerr(re_r), .mem_addr(ma_r), .mem_q(q_r));

  frame_mem_read_arb #(.ADDR_W(AW), .DATA_W(DW), .NCH(NCH), .MEM_DEPTH(DEPTH),
                       .MEM_LAT(LAT_P), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .ch_req(req_p), .ch_addr(adr_p), .ch_ack(ack_p),
    .ch_rvalid(rv_p), .ch_rdata(rd_p), .ch_rerr(re_p), .mem_addr(ma_p), .mem_q(q_p));

  function automatic logic [7:0] memval(input logic [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    q1_r <= memval(ma_r);
    q_r  <= q1_r;
    q_p  <= memval(ma_p);
  end

  typedef struct { int dut; int due; int ch; logic [7:0] data; logic err; } ret_t;
  ret_t        sb[$];
  int          ptr [2];
  logic [31:0] last [2];
  int          cyc, npass, ntot;
  logic [2:0]  ack_r_s, ack_p_s, rv_r_s;

  task automatic chk(input string nm, input bit d, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s dut%0d cyc%0d: got %0h, expected %0h", nm, d, cyc, act, exp);
  endtask

  // Reference: grant = first requester scanning from ptr (or from 0), data due lat cycles later.
  task automatic model(input bit d, input logic rstv, input logic [2:0] rq, input logic [95:0] ad,
                       input logic [2:0] ack, input logic [2:0] rv, input logic [7:0] rd,
                       input logic re, input logic [31:0] ma, output int g);
    int lat, c, hit;
    logic [31:0] a, ema;
    logic oor;
    ret_t e;
    lat = (d ? LAT_P : LAT_R) + XL;
    g = -1;
    if (rstv) begin
      for (int k = 0; k < NCH; k++) begin
        c = d ? k : (ptr[d] + k) % NCH;
        if (g < 0 && ((rq >> c) & 3'd1) != 3'd0) g = c;
      end
    end
    chk("ack", d, 64'(ack), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      a = 32'(ad >> (g * 32));
      oor = (a >= DEPTH);
      ema = oor ? 32'd0 : a;
    end else begin
      a = 32'd0;
      oor = 1'b0;
      ema = last[d];
    end
    chk("mem_addr", d, 64'(ma), 64'(ema));
    hit = -1;
    foreach (sb[k]) if (hit < 0 && sb[k].dut == int'(d)) hit = k;
    if (hit >= 0 && sb[hit].due == cyc) begin
      chk("rvalid", d, 64'(rv), 64'd1 << sb[hit].ch);
      chk("rdata", d, 64'(rd), 64'(sb[hit].data));
      chk("rerr", d, 64'(re), 64'(sb[hit].err));
      sb.delete(hit);
    end else begin
      chk("rvalid_idle", d, 64'(rv), 64'd0);
    end
    if (!rstv) begin
      for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].dut == int'(d)) sb.delete(k);
      ptr[d] = 0;
      last[d] = 32'd0;
    end else if (g >= 0) begin
      e.dut = int'(d);
      e.due = cyc + lat;
      e.ch = g;
      e.data = oor ? 8'd0 : memval(a);
      e.err = oor;
      sb.push_back(e);
      ptr[d] = (g + 1) % NCH;
      last[d] = ema;
    end
  endtask

  task automatic cycle(input logic rstv, input logic [2:0] rqr, input logic [2:0] rqp,
                       output int gr, output int gp);
    rst = rstv;
    req_r = rqr;
    req_p = rqp;
    @(negedge clk);
    ack_r_s = ack_r;
    ack_p_s = ack_p;
    rv_r_s = rv_r;
    model(1'b0, rstv, rqr, adr_r, ack_r, rv_r, rd_r, re_r, ma_r, gr);
    model(1'b1, rstv, rqp, adr_p, ack_p, rv_p, rd_p, re_p, ma_p, gp);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0: return 32'(DEPTH + $urandom_range(0, 3));
      1: return 32'hFFFF_FFF0;
      2: return 32'(DEPTH - 1);
      3: return 32'd0;
      default: return 32'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  task automatic upd(inout logic [2:0] rq, inout logic [95:0] ad, input int g);
    logic [2:0] m;
    for (int c = 0; c < NCH; c++) begin
      m = 3'(1 << c);
      if (g == c || (rq & m) == 3'd0) begin
        if ($urandom_range(0, 2) != 0) begin
          rq = rq | m;
          ad = (ad & ~(96'hFFFF_FFFF << (c * 32))) | (96'(rand_addr()) << (c * 32));
        end else begin
          rq = rq & ~m;
        end
      end
    end
  endtask

  typedef struct { logic [2:0] rq_r; logic [2:0] rq_p; logic [2:0] ea_r; logic [2:0] ea_p; } vec_t;
  vec_t tbl [10];

  initial begin
    int gr, gp, nack, nrv;
    logic [2:0] rq_r, rq_p;
    npass = 0; ntot = 0; cyc = 0;
    ptr[0] = 0; ptr[1] = 0; last[0] = 32'd0; last[1] = 32'd0;
    tbl[0] = '{3'b111, 3'b101, 3'b001, 3'b001};
    tbl[1] = '{3'b111, 3'b101, 3'b010, 3'b001};
    tbl[2] = '{3'b111, 3'b101, 3'b100, 3'b001};
    tbl[3] = '{3'b111, 3'b101, 3'b001, 3'b001};
    tbl[4] = '{3'b010, 3'b100, 3'b010, 3'b100};
    tbl[5] = '{3'b010, 3'b000, 3'b010, 3'b000};
    tbl[6] = '{3'b101, 3'b000, 3'b100, 3'b000};
    tbl[7] = '{3'b101, 3'b000, 3'b001, 3'b000};
    tbl[8] = '{3'b000, 3'b000, 3'b000, 3'b000};
    tbl[9] = '{3'b100, 3'b000, 3'b100, 3'b000};

    rst = 1'b0;
    req_r = 3'b111;
    req_p = 3'b111;
    adr_r = {32'h30, 32'h20, 32'h10};
    adr_p = {32'h33, 32'h22, 32'h11};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 1'b0, 64'(ack_r), 64'd0);
    chk("rst_ack", 1'b1, 64'(ack_p), 64'd0);
    chk("rst_rvalid", 1'b0, 64'(rv_r), 64'd0);
    chk("rst_rvalid", 1'b1, 64'(rv_p), 64'd0);
    chk("rst_mem_addr", 1'b0, 64'(ma_r), 64'd0);
    chk("rst_mem_addr", 1'b1, 64'(ma_p), 64'd0);
    chk("rst_rdata", 1'b0, 64'({rd_r, re_r}), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].rq_r, tbl[i].rq_p, gr, gp);
      chk("tbl_ack", 1'b0, 64'(ack_r_s), 64'(tbl[i].ea_r));
      chk("tbl_ack", 1'b1, 64'(ack_p_s), 64'(tbl[i].ea_p));
    end
    repeat (4) cycle(1'b1, 3'b000, 3'b000, gr, gp);

    nack = 0;
    nrv = 0;
    for (int i = 0; i < 12; i++) begin
      adr_r = {32'h30, 32'(i), 32'h10};
      cycle(1'b1, (i < 8) ? 3'b010 : 3'b000, 3'b000, gr, gp);
      if (ack_r_s == 3'b010) nack++;
      if (rv_r_s == 3'b010) nrv++;
    end
    chk("stream_acks", 1'b0, 64'(nack), 64'd8);
    chk("stream_rvalids", 1'b0, 64'(nrv), 64'd8);

    adr_r = {32'(DEPTH), 32'h20, 32'h10};
    cycle(1'b1, 3'b100, 3'b000, gr, gp);
    adr_r = {32'(DEPTH - 1), 32'h20, 32'h10};
    cycle(1'b1, 3'b100, 3'b000, gr, gp);
    repeat (4) cycle(1'b1, 3'b000, 3'b000, gr, gp);

    adr_r = {32'h30, 32'h20, 32'h5};
    cycle(1'b1, 3'b001, 3'b000, gr, gp);
    chk("midrst_ack", 1'b0, 64'(ack_r_s), 64'd1);
    cycle(1'b0, 3'b000, 3'b000, gr, gp);
    nrv = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 3'b000, 3'b000, gr, gp);
      if (rv_r_s != 3'b000) nrv++;
    end
    chk("midrst_no_rvalid", 1'b0, 64'(nrv), 64'd0);

    rq_r = 3'b000;
    rq_p = 3'b000;
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 99) != 0), rq_r, rq_p, gr, gp);
      upd(rq_r, adr_r, gr);
      upd(rq_p, adr_p, gp);
    end
    repeat (6) cycle(1'b1, 3'b000, 3'b000, gr, gp);
    chk("sb_drained", 1'b0, 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
